// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory-stage controller.
//   mem_size_e  - access size encoding (byte/half/word/dword)
//   mem_state_e - controller FSM states
//   size_bytes  - number of bytes covered by an access size
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    HOLD      = 2'd3
  } mem_state_e;

  function automatic logic [3:0] size_bytes(mem_size_e size);
    case (size)
      BYTE:    return 4'd1;
      HALF:    return 4'd2;
      WORD:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering between the register
// file view (LSB-aligned) and the cache word view (lane-positioned).
// Ports:
//   offset      in  byte offset of the access within the cache word
//   size        in  access size
//   is_unsigned in  zero-extend loads when set
//   rdata       in  full aligned cache word from a load response
//   store_data  in  LSB-aligned store operand
//   load_data   out rdata shifted down to bit 0 and sign/zero extended
//   wdata       out store_data shifted up to its byte lane
//   wstrb       out byte enables covering the store lanes
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  offset,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   rdata,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   load_data,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb
);

  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep_mask;
  logic              sign_bit;
  logic [STRB_W-1:0] base_strb;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    keep_mask = '1;
    sign_bit  = 1'b0;
    base_strb = '1;
    case (size)
      BYTE: begin
        keep_mask = XLEN'(8'hFF);
        sign_bit  = shifted[7];
        base_strb = STRB_W'(4'h1);
      end
      HALF: begin
        keep_mask = XLEN'(16'hFFFF);
        sign_bit  = shifted[15];
        base_strb = STRB_W'(4'h3);
      end
      WORD: begin
        // On a 32-bit datapath the mask is all ones, so no extension happens.
        keep_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
        base_strb = STRB_W'(4'hF);
      end
      default: ;
    endcase
    load_data = (shifted & keep_mask) |
                ((sign_bit && !is_unsigned) ? ~keep_mask : '0);
    wdata     = store_data << {offset, 3'b000};
    wstrb     = base_strb << offset;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between EX/MEM and MEM/WB.
// Accepts one op per in_valid/in_ready handshake, issues a single data
// cache request for loads/stores, and presents the result on out_*.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_*                  op from EX/MEM (valid/ready, flags, size, addr, data)
//   icache_busy           instruction cache owns the shared AXI port
//   req_*                 data cache request (valid/ready, write, addr, wdata, wstrb)
//   resp_valid/resp_rdata one-cycle cache response with the aligned word
//   out_*                 result to MEM/WB (valid/ready, data, fault)
//
// state     | meaning
// IDLE      | ready for a new op
// REQ       | request held for the cache, paused while icache_busy
// WAIT_RESP | request accepted, waiting for the response pulse
// HOLD      | result presented until MEM/WB takes it
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic              icache_busy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [STRB_W-1:0] req_wstrb,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_fault
);

  localparam int OFF_W = $clog2(STRB_W);

  mem_state_e        state, state_n;
  logic [ADDR_W-1:0] addr_q;
  mem_size_e         size_q;
  logic              unsigned_q;
  logic              write_q;
  logic [XLEN-1:0]   store_data_q;
  logic [XLEN-1:0]   out_data_q;
  logic              out_fault_q;

  logic              non_mem;
  logic              fault_c;
  logic [3:0]        nbytes;
  logic [2:0]        align_mask;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wdata;
  logic [STRB_W-1:0] wstrb;
  logic              req_live;

  // Alignment check: the low address bits covered by the access size must be zero.
  always_comb begin
    non_mem    = !in_is_load && !in_is_store;
    nbytes     = size_bytes(mem_size_e'(in_size));
    align_mask = nbytes[2:0] - 3'd1;
    fault_c    = ((in_addr[2:0] & align_mask) != 3'd0) ||
                 ((XLEN == 32) && (in_size == 2'd3));
  end

  mem_lane_align #(
    .XLEN   (XLEN),
    .STRB_W (STRB_W),
    .OFF_W  (OFF_W)
  ) u_lane_align (
    .offset      (addr_q[OFF_W-1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (resp_rdata),
    .store_data  (store_data_q),
    .load_data   (load_data),
    .wdata       (wdata),
    .wstrb       (wstrb)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    req_valid = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (non_mem || fault_c) ? HOLD : REQ;
      end
      REQ: begin
        req_valid = !icache_busy;
        if (req_valid && req_ready) state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_valid) state_n = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (reset) begin
      in_ready  = 1'b0;
      req_valid = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      size_q       <= BYTE;
      unsigned_q   <= 1'b0;
      write_q      <= 1'b0;
      store_data_q <= '0;
      out_data_q   <= '0;
      out_fault_q  <= 1'b0;
    end else if (in_valid && in_ready) begin
      addr_q       <= in_addr;
      size_q       <= mem_size_e'(in_size);
      unsigned_q   <= in_unsigned;
      write_q      <= in_is_store;
      store_data_q <= in_store_data;
      out_fault_q  <= !non_mem && fault_c;
      out_data_q   <= non_mem ? XLEN'(in_addr) : '0;
    end else if (state == WAIT_RESP && resp_valid) begin
      out_data_q   <= write_q ? '0 : load_data;
    end
  end

  // Request fields are only driven while a request is pending so the bus
  // reads zero otherwise; in REQ they come straight from the op registers.
  assign req_live  = (state == REQ) && !reset;
  assign req_write = req_live && write_q;
  assign req_addr  = req_live ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign req_wdata = (req_live && write_q) ? wdata : '0;
  assign req_wstrb = (req_live && write_q) ? wstrb : '0;
  assign out_data  = out_data_q;
  assign out_fault = out_fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scoreboard bench for mem_stage_ctrl (XLEN=64).
// Stimulus pushes expected requests/results into queues; a monitor pops and
// compares on each req and out handshake.
module tb_mem_stage_ctrl;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;
  localparam int STRB_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_is_load = 1'b0;
  logic              in_is_store = 1'b0;
  logic [1:0]        in_size = 2'd0;
  logic              in_unsigned = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [XLEN-1:0]   in_store_data = '0;
  logic              icache_busy = 1'b0;
  logic              req_valid;
  logic              req_ready = 1'b1;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              resp_valid = 1'b0;
  logic [XLEN-1:0]   resp_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [XLEN-1:0]   out_data;
  logic              out_fault;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .icache_busy   (icache_busy),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_fault     (out_fault)
  );

  typedef struct {
    logic [63:0] data;
    logic        fault;
  } out_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_exp_t;

  out_exp_t out_q[$];
  req_exp_t req_q[$];
  out_exp_t mon_o;
  req_exp_t mon_r;
  int n_vec = 0;
  int n_miss = 0;
  int n_req_hs = 0;
  int n_req_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: handshake not seen within cycle budget", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL out_unexpected: got data 0x%0h fault %0b, expected no result", out_data, out_fault);
        end else begin
          mon_o = out_q.pop_front();
          check("out_data", out_data, mon_o.data);
          check("out_fault", out_fault, mon_o.fault);
        end
      end
      if (req_valid && req_ready) begin
        n_req_hs++;
        if (req_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL req_unexpected: got addr 0x%0h, expected no request", req_addr);
        end else begin
          mon_r = req_q.pop_front();
          check("req_addr", req_addr, mon_r.addr);
          check("req_write", req_write, mon_r.write);
          check("req_wdata", req_wdata, mon_r.wdata);
          check("req_wstrb", req_wstrb, mon_r.wstrb);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic accept(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sdata);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_size       = sz;
    in_unsigned   = uns;
    in_addr       = addr;
    in_store_data = sdata;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
  endtask

  task automatic wait_req_hs(input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = req_valid && req_ready;
      @(posedge clk); #1;
    end
    if (!found) timeout("req_handshake");
  endtask

  task automatic wait_out_hs(input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = out_valid && out_ready;
      @(posedge clk); #1;
    end
    if (!found) timeout("out_handshake");
  endtask

  task automatic respond(input logic [63:0] rdata);
    resp_valid = 1'b1;
    resp_rdata = rdata;
    @(posedge clk); #1;
    resp_valid = 1'b0;
  endtask

  task automatic mem_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                        input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                        input logic [7:0] exp_wstrb, input logic [63:0] exp_out);
    req_q.push_back('{exp_addr, st, exp_wdata, exp_wstrb});
    out_q.push_back('{exp_out, 1'b0});
    n_req_exp++;
    accept(ld, st, sz, uns, addr, sdata);
    @(negedge clk);
    check("req_latency", req_valid, 1);
    @(posedge clk); #1;
    respond(rdata);
    @(negedge clk);
    check("out_latency", out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic fault_op(input logic ld, input logic st, input logic [1:0] sz, input logic [63:0] addr);
    out_q.push_back('{64'h0, 1'b1});
    accept(ld, st, sz, 1'b0, addr, 64'hFFFF_FFFF);
    @(negedge clk);
    check("fault_out_latency", out_valid, 1);
    check("fault_no_req", req_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_data", out_data, 0);
    check("post_rst_out_fault", out_fault, 0);
    check("post_rst_req_addr", req_addr, 0);
    @(posedge clk); #1;

    // Loads: sign/zero extension across sizes and lane offsets
    mem_op(1, 0, 2'd0, 0, 64'h1003, 64'hFFFF, 64'h1122_3344_8066_7788, 64'h1000, 0, 0, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op(1, 0, 2'd0, 1, 64'h1003, 64'hFFFF, 64'h1122_3344_8066_7788, 64'h1000, 0, 0, 64'h80);
    mem_op(1, 0, 2'd1, 0, 64'h1006, 64'h0,    64'h8123_0000_0000_0000, 64'h1000, 0, 0, 64'hFFFF_FFFF_FFFF_8123);
    mem_op(1, 0, 2'd1, 1, 64'h1002, 64'h0,    64'h0000_0000_F00D_0000, 64'h1000, 0, 0, 64'hF00D);
    mem_op(1, 0, 2'd2, 0, 64'h1004, 64'h0,    64'h8000_0001_1234_5678, 64'h1000, 0, 0, 64'hFFFF_FFFF_8000_0001);
    mem_op(1, 0, 2'd2, 1, 64'h1004, 64'h0,    64'h8000_0001_1234_5678, 64'h1000, 0, 0, 64'h8000_0001);
    mem_op(1, 0, 2'd2, 0, 64'h1000, 64'h0,    64'hFFFF_FFFF_7FFF_FFFF, 64'h1000, 0, 0, 64'h7FFF_FFFF);
    mem_op(1, 0, 2'd3, 0, 64'h1008, 64'h0,    64'h0123_4567_89AB_CDEF, 64'h1008, 0, 0, 64'h0123_4567_89AB_CDEF);

    // Stores: lane-shifted data and strobes, result 0
    mem_op(0, 1, 2'd1, 0, 64'h2006, 64'hABCD,                64'hDEAD, 64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, 0);
    mem_op(0, 1, 2'd0, 0, 64'h2003, 64'h5A,                  64'h0,    64'h2000, 64'h5A00_0000,           8'h08, 0);
    mem_op(0, 1, 2'd2, 0, 64'h2004, 64'hCAFE_BABE,           64'h0,    64'h2000, 64'hCAFE_BABE_0000_0000, 8'hF0, 0);
    mem_op(0, 1, 2'd3, 0, 64'h2008, 64'h0123_4567_89AB_CDEF, 64'h0,    64'h2008, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);

    // Misaligned accesses fault without touching the cache
    fault_op(1, 0, 2'd2, 64'h3002);
    fault_op(0, 1, 2'd1, 64'h3001);
    fault_op(1, 0, 2'd3, 64'h3004);

    // Non-memory op held by MEM/WB backpressure
    out_ready = 1'b0;
    out_q.push_back('{64'h42, 1'b0});
    accept(0, 0, 2'd0, 0, 64'h42, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, 64'h42);
      check("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_out_hs(4);

    // Port arbitration with the instruction cache and request backpressure
    icache_busy = 1'b1;
    req_ready   = 1'b0;
    req_q.push_back('{64'h4000, 1'b0, 64'h0, 8'h00});
    out_q.push_back('{64'hFFFF_FFFF_8765_4321, 1'b0});
    n_req_exp++;
    accept(1, 0, 2'd2, 0, 64'h4004, 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("req_while_busy", req_valid, 0);
      @(posedge clk); #1;
    end
    icache_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("req_stalled_valid", req_valid, 1);
      check("req_stalled_addr", req_addr, 64'h4000);
      @(posedge clk); #1;
    end
    icache_busy = 1'b1;
    @(negedge clk);
    check("req_drop_on_busy", req_valid, 0);
    @(posedge clk); #1;
    icache_busy = 1'b0;
    req_ready   = 1'b1;
    wait_req_hs(4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("no_req_while_waiting", req_valid, 0);
      check("no_out_while_waiting", out_valid, 0);
      @(posedge clk); #1;
    end
    respond(64'h8765_4321_0000_0000);
    wait_out_hs(4);

    // Reset during WAIT_RESP, then a stray response
    req_q.push_back('{64'h5010, 1'b0, 64'h0, 8'h00});
    n_req_exp++;
    accept(1, 0, 2'd2, 0, 64'h5010, 64'h0);
    wait_req_hs(4);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_in_reset", in_ready, 0);
    check("out_valid_in_reset", out_valid, 0);
    @(posedge clk); #1;
    reset      = 1'b0;
    resp_valid = 1'b1;
    resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_req_valid", req_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_data", out_data, 0);
    check("abort_out_fault", out_fault, 0);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    check("stray_resp_ignored", out_valid, 0);
    @(posedge clk); #1;
    mem_op(1, 0, 2'd1, 0, 64'h6002, 64'h0, 64'h0000_0000_1234_0000, 64'h6000, 0, 0, 64'h1234);

    // End-of-run accounting
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("req_count", n_req_hs, n_req_exp);
    check("out_queue_left", out_q.size(), 0);
    check("req_queue_left", req_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
